sdram_nport_arbiter: RTL and testbench
======================================

SDRAM_NPORT_ARBITER -- requirements
Module: sdram_nport_arbiter

Interface
REQ-001 SHALL have parameter CH_NUM, default 4, number of channels (2..8).
REQ-002 SHALL have parameter ADDR_W, default 24, SDRAM word-address width.
REQ-003 SHALL have parameter LEN_W, default 10, burst-length width.
REQ-004 SHALL have parameter LVL_W, default 10, FIFO fill-level width.
REQ-005 SHALL have ports, one per line, as follows:
- clk  in  1  controller clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- sdram_init_done  in  1  SDRAM initialisation complete.
- sdram_pingpang_en  in  1  ping-pong banking enable.
- ch_min_addr  in  CH_NUM*ADDR_W  per-channel start address; channel i at [i*ADDR_W +: ADDR_W].
- ch_max_addr  in  CH_NUM*ADDR_W  per-channel end address (exclusive).
- wr_length  in  LEN_W  write burst length.
- rd_length  in  LEN_W  read burst length.
- ch_wr_level  in  CH_NUM*LVL_W  words waiting in each channel's write FIFO.
- ch_rd_level  in  CH_NUM*LVL_W  words held in each channel's read FIFO.
- ch_rd_en  in  CH_NUM  channel read side active.
- ch_wr_load  in  CH_NUM  per-channel write-pointer reset pulse.
- ch_rd_load  in  CH_NUM  per-channel read-pointer reset pulse.
- sdram_wr_req  out  1  write request.
- sdram_wr_ack  in  1  write ack, high for the whole data phase.
- sdram_wr_addr  out  ADDR_W  write burst address.
- sdram_rd_req  out  1  read request.
- sdram_rd_ack  in  1  read ack, high for the whole data phase.
- sdram_rd_addr  out  ADDR_W  read burst address.
- grant_ch  out  $clog2(CH_NUM)  channel owning the current burst, for FIFO data muxing.
- grant_wr  out  1  1 = current burst is a write.
- busy  out  1  high outside IDLE/ARB.

Function
REQ-006 FSM states SHALL be IDLE, ARB, REQ, XFER, DONE; IDLE->ARB when sdram_init_done=1.
REQ-007 Write eligibility for channel i SHALL be ch_wr_level[i] >= wr_length, with wr_length != 0.
REQ-008 Read eligibility for channel i SHALL be ch_rd_en[i]=1 and ch_rd_level[i] < rd_length.
REQ-009 In ARB, the FSM SHALL scan channels round-robin, starting at last granted + 1, and grant the first eligible channel.
- Within one channel, write SHALL take precedence over read.
- With no eligible channel, the FSM SHALL stay in ARB.
- ARB->REQ SHALL take exactly 1 cycle; grant_ch, grant_wr and the address SHALL be latched on that edge.
REQ-010 In REQ, the FSM SHALL hold sdram_wr_req (or sdram_rd_req) high with a stable address until the matching ack is sampled high, then go to XFER and deassert req on the same edge.
REQ-011 The FSM SHALL go XFER->DONE on the first cycle the ack is sampled low, and DONE->ARB unconditionally after 1 cycle.
REQ-012 The burst address SHALL be min_addr + pointer, with the MSB replaced by the bank bit when ping-pong is enabled.
REQ-013 In DONE, the granted pointer SHALL advance by its burst length.
- If the advanced value is greater than (max - min - length), the pointer SHALL wrap to 0.
REQ-014 On a write-pointer wrap with ping-pong enabled, the channel's write bank bit SHALL toggle.
REQ-015 On a read-pointer wrap with ping-pong enabled, the read bank SHALL be set to the inverse of that channel's current write bank.
REQ-016 With ping-pong disabled, bank bits SHALL be ignored and the address MSB SHALL come from min_addr + pointer.
REQ-017 ch_wr_load[i] / ch_rd_load[i] SHALL clear that pointer and bank bit at the next edge.
- If channel i is mid-burst, the burst SHALL complete on its latched address.
- DONE SHALL skip the advance for a pointer loaded during that burst.
- A load in the same cycle as DONE SHALL win over the advance.
REQ-018 Pointer arithmetic SHALL be ADDR_W bits, unsigned, with no overflow beyond the wrap rule.

Reset
REQ-019 While rst=1 at a clk edge, the block SHALL enter IDLE with all outputs 0, all pointers and bank bits 0, and the round-robin pointer set to CH_NUM-1 (first scan starts at channel 0).
REQ-020 Reset mid-burst SHALL drop req immediately; no partial pointer update SHALL occur.

Structure
REQ-021 Package sdram_arb_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-022 The round-robin priority picker SHALL be one sub-module, rr_pick (CH_NUM-bit request vector plus last-grant in, grant index plus valid out).

Verification
REQ-023 CH_NUM=4, wr_length=256, all ch_wr_level=300 -> grants 0,1,2,3,0 in order; each req holds until ack.
REQ-024 Channel 2 wr_level=256 and rd eligible -> write burst first, then read on channel 2 only after the other channels are scanned.
REQ-025 min=0, max=1024, wr_length=256, ping-pong on -> addresses 0,256,512,768 then 0x800000 (bank toggled).
REQ-026 ch_wr_load[1] pulsed during a channel 1 write XFER -> the current burst uses the old address; the next channel 1 burst address equals min_addr.
REQ-027 rst asserted in REQ -> the next cycle has sdram_wr_req=0, busy=0, and pointers zero.
REQ-028 sdram_init_done=0 with all channels eligible -> no req asserted for 100 cycles.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and default sizing for the multi-port SDRAM burst arbiter.
package sdram_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_REQ,
    ST_XFER,
    ST_DONE
  } arb_state_e;

  localparam int DEF_CH_NUM = 4;
  localparam int DEF_ADDR_W = 24;
  localparam int DEF_LEN_W  = 10;
  localparam int DEF_LVL_W  = 10;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request bit found scanning upward from last_i + 1.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  // Walk the scan backwards so the candidate nearest to last_i + 1 overwrites the rest.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (req_i[(int'(last_i) + k) % N]) begin
        idx_o = IW'((int'(last_i) + k) % N);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_nport_arbiter.sv
// Arbitrates SDRAM write/read bursts between CH_NUM FIFO channels, owning per-channel
// address pointers with optional ping-pong banking on the address MSB.
module sdram_nport_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int CH_NUM = DEF_CH_NUM,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int LVL_W  = DEF_LVL_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sdram_init_done,
  input  logic                       sdram_pingpang_en,
  input  logic [CH_NUM*ADDR_W-1:0]   ch_min_addr,
  input  logic [CH_NUM*ADDR_W-1:0]   ch_max_addr,
  input  logic [LEN_W-1:0]           wr_length,
  input  logic [LEN_W-1:0]           rd_length,
  input  logic [CH_NUM*LVL_W-1:0]    ch_wr_level,
  input  logic [CH_NUM*LVL_W-1:0]    ch_rd_level,
  input  logic [CH_NUM-1:0]          ch_rd_en,
  input  logic [CH_NUM-1:0]          ch_wr_load,
  input  logic [CH_NUM-1:0]          ch_rd_load,
  output logic                       sdram_wr_req,
  input  logic                       sdram_wr_ack,
  output logic [ADDR_W-1:0]          sdram_wr_addr,
  output logic                       sdram_rd_req,
  input  logic                       sdram_rd_ack,
  output logic [ADDR_W-1:0]          sdram_rd_addr,
  output logic [$clog2(CH_NUM)-1:0]  grant_ch,
  output logic                       grant_wr,
  output logic                       busy
);

  localparam int IW = $clog2(CH_NUM);
  localparam int CW = (LVL_W > LEN_W) ? LVL_W : LEN_W;

  arb_state_e        state_q;
  logic [IW-1:0]     last_q;
  logic [ADDR_W-1:0] wr_ptr_q [CH_NUM];
  logic [ADDR_W-1:0] rd_ptr_q [CH_NUM];
  logic [CH_NUM-1:0] wr_bank_q, rd_bank_q;
  logic [LEN_W-1:0]  len_q;
  logic              skip_q;

  logic [CH_NUM-1:0] wr_elig, rd_elig, any_elig;
  logic [IW-1:0]     pick_idx;
  logic              pick_vld, pick_wr, bank_sel, ack_d, wrap_d;
  logic [ADDR_W-1:0] min_sel, ptr_sel, addr_d;
  logic [ADDR_W-1:0] g_min, g_max, g_ptr, adv_d, lim_d;

  always_comb begin
    wr_elig = '0;
    rd_elig = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      wr_elig[i] = (wr_length != '0) &&
                   (CW'(ch_wr_level[i*LVL_W +: LVL_W]) >= CW'(wr_length));
      rd_elig[i] = ch_rd_en[i] &&
                   (CW'(ch_rd_level[i*LVL_W +: LVL_W]) < CW'(rd_length));
    end
  end

  assign any_elig = wr_elig | rd_elig;

  rr_pick #(.N(CH_NUM)) u_pick (
    .req_i  (any_elig),
    .last_i (last_q),
    .idx_o  (pick_idx),
    .vld_o  (pick_vld)
  );

  // Address of the burst about to be granted; write wins within a channel.
  always_comb begin
    pick_wr  = wr_elig[pick_idx];
    min_sel  = ch_min_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
    ptr_sel  = pick_wr ? wr_ptr_q[pick_idx] : rd_ptr_q[pick_idx];
    bank_sel = pick_wr ? wr_bank_q[pick_idx] : rd_bank_q[pick_idx];
    addr_d   = min_sel + ptr_sel;
    if (sdram_pingpang_en) addr_d[ADDR_W-1] = bank_sel;
  end

  // Pointer advance for the granted burst, evaluated in DONE.
  always_comb begin
    ack_d  = grant_wr ? sdram_wr_ack : sdram_rd_ack;
    g_min  = ch_min_addr[int'(grant_ch)*ADDR_W +: ADDR_W];
    g_max  = ch_max_addr[int'(grant_ch)*ADDR_W +: ADDR_W];
    g_ptr  = grant_wr ? wr_ptr_q[grant_ch] : rd_ptr_q[grant_ch];
    adv_d  = g_ptr + ADDR_W'(len_q);
    lim_d  = g_max - g_min - ADDR_W'(len_q);
    wrap_d = adv_d > lim_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_q        <= IW'(CH_NUM - 1);
      wr_bank_q     <= '0;
      rd_bank_q     <= '0;
      len_q         <= '0;
      skip_q        <= 1'b0;
      sdram_wr_req  <= 1'b0;
      sdram_rd_req  <= 1'b0;
      sdram_wr_addr <= '0;
      sdram_rd_addr <= '0;
      grant_ch      <= '0;
      grant_wr      <= 1'b0;
      busy          <= 1'b0;
      for (int i = 0; i < CH_NUM; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: if (sdram_init_done) state_q <= ST_ARB;
        ST_ARB: begin
          if (pick_vld) begin
            state_q  <= ST_REQ;
            last_q   <= pick_idx;
            grant_ch <= pick_idx;
            grant_wr <= pick_wr;
            len_q    <= pick_wr ? wr_length : rd_length;
            skip_q   <= pick_wr ? ch_wr_load[pick_idx] : ch_rd_load[pick_idx];
            busy     <= 1'b1;
            if (pick_wr) begin
              sdram_wr_req  <= 1'b1;
              sdram_wr_addr <= addr_d;
            end else begin
              sdram_rd_req  <= 1'b1;
              sdram_rd_addr <= addr_d;
            end
          end
        end
        ST_REQ: begin
          if (ack_d) begin
            state_q      <= ST_XFER;
            sdram_wr_req <= 1'b0;
            sdram_rd_req <= 1'b0;
          end
        end
        ST_XFER: if (!ack_d) state_q <= ST_DONE;
        ST_DONE: begin
          state_q <= ST_ARB;
          busy    <= 1'b0;
          if (!skip_q) begin
            if (grant_wr) begin
              wr_ptr_q[grant_ch] <= wrap_d ? '0 : adv_d;
              if (wrap_d && sdram_pingpang_en) wr_bank_q[grant_ch] <= ~wr_bank_q[grant_ch];
            end else begin
              rd_ptr_q[grant_ch] <= wrap_d ? '0 : adv_d;
              if (wrap_d && sdram_pingpang_en) rd_bank_q[grant_ch] <= ~wr_bank_q[grant_ch];
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // A load of the in-flight pointer cancels its advance; loads below override DONE.
      if ((state_q == ST_REQ || state_q == ST_XFER) &&
          (grant_wr ? ch_wr_load[grant_ch] : ch_rd_load[grant_ch]))
        skip_q <= 1'b1;

      for (int i = 0; i < CH_NUM; i++) begin
        if (ch_wr_load[i]) begin
          wr_ptr_q[i]  <= '0;
          wr_bank_q[i] <= 1'b0;
        end
        if (ch_rd_load[i]) begin
          rd_ptr_q[i]  <= '0;
          rd_bank_q[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_nport_arbiter.sv
// Randomised bench for sdram_nport_arbiter: a reference model predicts each granted
// burst into a queue, and a monitor checks every request the DUT raises against it.
`timescale 1ns/1ps
module tb_sdram_nport_arbiter;

  localparam int CH = 4;
  localparam int AW = 24;
  localparam int LW = 10;
  localparam int VW = 10;
  localparam int EW = 2 + 3 + AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic               sdram_init_done, sdram_pingpang_en;
  logic [CH*AW-1:0]   ch_min_addr, ch_max_addr;
  logic [LW-1:0]      wr_length, rd_length;
  logic [CH*VW-1:0]   ch_wr_level, ch_rd_level;
  logic [CH-1:0]      ch_rd_en, ch_wr_load, ch_rd_load;
  logic               sdram_wr_req, sdram_wr_ack, sdram_rd_req, sdram_rd_ack;
  logic [AW-1:0]      sdram_wr_addr, sdram_rd_addr;
  logic [1:0]         grant_ch;
  logic               grant_wr, busy;

  logic [AW-1:0] in_min [CH];
  logic [AW-1:0] in_max [CH];
  logic [VW-1:0] in_wlvl [CH];
  logic [VW-1:0] in_rlvl [CH];

  always_comb begin
    ch_min_addr = '0;
    ch_max_addr = '0;
    ch_wr_level = '0;
    ch_rd_level = '0;
    for (int i = 0; i < CH; i++) begin
      ch_min_addr[i*AW +: AW] = in_min[i];
      ch_max_addr[i*AW +: AW] = in_max[i];
      ch_wr_level[i*VW +: VW] = in_wlvl[i];
      ch_rd_level[i*VW +: VW] = in_rlvl[i];
    end
  end

  sdram_nport_arbiter #(.CH_NUM(CH), .ADDR_W(AW), .LEN_W(LW), .LVL_W(VW)) dut (
    .clk               (clk),
    .rst               (rst),
    .sdram_init_done   (sdram_init_done),
    .sdram_pingpang_en (sdram_pingpang_en),
    .ch_min_addr       (ch_min_addr),
    .ch_max_addr       (ch_max_addr),
    .wr_length         (wr_length),
    .rd_length         (rd_length),
    .ch_wr_level       (ch_wr_level),
    .ch_rd_level       (ch_rd_level),
    .ch_rd_en          (ch_rd_en),
    .ch_wr_load        (ch_wr_load),
    .ch_rd_load        (ch_rd_load),
    .sdram_wr_req      (sdram_wr_req),
    .sdram_wr_ack      (sdram_wr_ack),
    .sdram_wr_addr     (sdram_wr_addr),
    .sdram_rd_req      (sdram_rd_req),
    .sdram_rd_ack      (sdram_rd_ack),
    .sdram_rd_addr     (sdram_rd_addr),
    .grant_ch          (grant_ch),
    .grant_wr          (grant_wr),
    .busy              (busy)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  logic [AW-1:0] m_wptr [CH];
  logic [AW-1:0] m_rptr [CH];
  bit            m_wbank [CH];
  bit            m_rbank [CH];
  int            m_last;
  int            m_cur_ch;
  bit            m_cur_wr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic report();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_wptr[i] = '0; m_rptr[i] = '0; m_wbank[i] = 0; m_rbank[i] = 0;
    end
    m_last = CH - 1;
    exp_q.delete();
  endtask

  function automatic bit elig_wr(input int c);
    return (wr_length != 0) && (in_wlvl[c] >= wr_length);
  endfunction

  function automatic bit elig_rd(input int c);
    return ch_rd_en[c] && (in_rlvl[c] < rd_length);
  endfunction

  // Next grant from the current inputs: push expected burst, then advance the model.
  task automatic predict();
    int c; bit found, wr; bit bank;
    logic [AW-1:0] p, a, adv, lim, len;
    logic [1:0] cc;
    found = 0; c = 0; wr = 0;
    for (int k = 1; k <= CH; k++) begin
      int cand;
      cand = (m_last + k) % CH;
      if (!found && (elig_wr(cand) || elig_rd(cand))) begin
        found = 1; c = cand; wr = elig_wr(cand);
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL predict_no_eligible: stimulus left no channel eligible");
      return;
    end
    p    = wr ? m_wptr[c] : m_rptr[c];
    bank = wr ? m_wbank[c] : m_rbank[c];
    len  = AW'(wr ? wr_length : rd_length);
    a    = in_min[c] + p;
    if (sdram_pingpang_en) a[AW-1] = bank;
    cc = c[1:0];
    exp_q.push_back({cc, wr, wr, !wr, a});
    m_last = c; m_cur_ch = c; m_cur_wr = wr;
    adv = p + len;
    lim = in_max[c] - in_min[c] - len;
    if (adv > lim) begin
      adv = '0;
      if (sdram_pingpang_en) begin
        if (wr) m_wbank[c] = !m_wbank[c];
        else    m_rbank[c] = !m_wbank[c];
      end
    end
    if (wr) m_wptr[c] = adv; else m_rptr[c] = adv;
  endtask

  // ---------------- monitor ----------------
  logic          prev_req = 1'b0;
  logic          cur_req;
  logic [AW-1:0] held_addr, cur_addr;
  logic [EW-1:0] act_e, exp_e;

  always @(negedge clk) begin
    cur_req  = sdram_wr_req | sdram_rd_req;
    cur_addr = grant_wr ? sdram_wr_addr : sdram_rd_addr;
    if (rst) begin
      prev_req = 1'b0;
    end else begin
      if (cur_req && !prev_req) begin
        act_e = {grant_ch, grant_wr, sdram_wr_req, sdram_rd_req, cur_addr};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_req: got ch=%0d wr=%0b addr=%0h with nothing expected",
                   grant_ch, grant_wr, cur_addr);
        end else begin
          exp_e = exp_q.pop_front();
          if (act_e !== exp_e) begin
            errors++;
            $display("FAIL grant: got ch=%0d wr=%0b req=%0b%0b addr=%0h expected ch=%0d wr=%0b req=%0b%0b addr=%0h",
                     act_e[EW-1 -: 2], act_e[AW+2], act_e[AW+1], act_e[AW], act_e[AW-1:0],
                     exp_e[EW-1 -: 2], exp_e[AW+2], exp_e[AW+1], exp_e[AW], exp_e[AW-1:0]);
          end
        end
        held_addr = cur_addr;
      end else if (cur_req) begin
        checks++;
        if (cur_addr !== held_addr || busy !== 1'b1) begin
          errors++;
          $display("FAIL req_hold: got addr=%0h busy=%0b required addr=%0h busy=1",
                   cur_addr, busy, held_addr);
        end
      end
      prev_req = cur_req;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_req();
    int w;
    w = 0;
    while (!(sdram_wr_req || sdram_rd_req) && w < 60) begin tick(); w++; end
    chk("req_within_budget", (w < 60), 1);
    if (w >= 60) report();
  endtask

  task automatic ack_up();
    repeat ($urandom_range(0, 3)) tick();
    if (sdram_wr_req) sdram_wr_ack = 1'b1; else sdram_rd_ack = 1'b1;
    tick();
    chk("req_drop_on_ack", {30'd0, sdram_wr_req, sdram_rd_req}, 0);
    chk("busy_in_xfer", busy, 1);
  endtask

  task automatic ack_down();
    repeat ($urandom_range(0, 3)) tick();
    sdram_wr_ack = 1'b0;
    sdram_rd_ack = 1'b0;
  endtask

  task automatic pulse_load(input int c, input bit wr);
    if (wr) begin ch_wr_load[c] = 1'b1; m_wptr[c] = '0; m_wbank[c] = 0; end
    else    begin ch_rd_load[c] = 1'b1; m_rptr[c] = '0; m_rbank[c] = 0; end
    tick();
    ch_wr_load = '0;
    ch_rd_load = '0;
  endtask

  task automatic gen_random();
    int c;
    bit any;
    case ($urandom_range(0, 4))
      0: wr_length = LW'(0);
      1: wr_length = LW'(64);
      2: wr_length = LW'(128);
      3: wr_length = LW'(256);
      default: wr_length = LW'(300);
    endcase
    rd_length = LW'($urandom_range(1, 300));
    for (int i = 0; i < CH; i++) begin
      in_wlvl[i]  = VW'($urandom_range(0, 400));
      in_rlvl[i]  = VW'($urandom_range(0, 400));
      ch_rd_en[i] = 1'($urandom_range(0, 1));
    end
    any = 0;
    for (int i = 0; i < CH; i++) any |= elig_wr(i) | elig_rd(i);
    if (!any) begin
      c = $urandom_range(0, CH - 1);
      ch_rd_en[c] = 1'b1;
      in_rlvl[c]  = '0;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin : watchdog
    #600000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time budget");
    report();
  end

  initial begin : stim
    int c, cnt;
    bit wr;
    sdram_init_done = 0; sdram_pingpang_en = 0;
    wr_length = '0; rd_length = '0;
    ch_rd_en = '0; ch_wr_load = '0; ch_rd_load = '0;
    sdram_wr_ack = 0; sdram_rd_ack = 0;
    for (int i = 0; i < CH; i++) begin
      in_min[i] = '0; in_max[i] = '0; in_wlvl[i] = '0; in_rlvl[i] = '0;
    end
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    chk("rst_wr_req",  sdram_wr_req, 0);
    chk("rst_rd_req",  sdram_rd_req, 0);
    chk("rst_busy",    busy, 0);
    chk("rst_grant_ch", grant_ch, 0);
    chk("rst_grant_wr", grant_wr, 0);
    chk("rst_wr_addr", sdram_wr_addr, 0);
    chk("rst_rd_addr", sdram_rd_addr, 0);

    // Every channel write-eligible, ping-pong on, channel 0 spans [0,1024).
    sdram_pingpang_en = 1;
    wr_length = LW'(256);
    for (int i = 0; i < CH; i++) begin
      in_min[i]  = AW'(i * 'h10000);
      in_max[i]  = in_min[i] + AW'(1024);
      in_wlvl[i] = VW'(300);
    end
    cnt = 0;
    repeat (100) begin
      tick();
      if (sdram_wr_req || sdram_rd_req || busy) cnt++;
    end
    chk("no_req_before_init", cnt, 0);

    predict();
    sdram_init_done = 1;
    for (int b = 0; b < 20; b++) begin
      wait_req();
      ack_up();
      if (b == 9) pulse_load(1, 1);
      predict();
      ack_down();
    end

    // Reset while a request is pending must drop it at once and clear pointers.
    wait_req();
    rst = 1'b1;
    tick();
    chk("rst_in_req_wr_req", sdram_wr_req, 0);
    chk("rst_in_req_busy", busy, 0);
    model_reset();

    // Only channel 2 (write and read) and channel 3 (read) compete first.
    sdram_pingpang_en = 1'($urandom_range(0, 1));
    for (int i = 0; i < CH; i++) begin
      in_min[i]  = AW'($urandom_range(0, 'h3fff)) + AW'(i * 'h40000);
      in_max[i]  = in_min[i] + AW'($urandom_range(600, 1500));
      in_wlvl[i] = '0;
      in_rlvl[i] = VW'(400);
    end
    wr_length = LW'(256);
    rd_length = LW'(100);
    in_wlvl[2] = VW'(256);
    ch_rd_en = 4'b1100;
    in_rlvl[2] = VW'(10);
    in_rlvl[3] = VW'(20);
    predict();
    tick();
    rst = 1'b0;

    for (int b = 0; b < 40; b++) begin
      wait_req();
      ack_up();
      if (b >= 2 && $urandom_range(0, 3) == 0) begin
        c  = $urandom_range(0, CH - 1);
        wr = 1'($urandom_range(0, 1));
        if (!(wr && !m_cur_wr && c == m_cur_ch)) pulse_load(c, wr);
      end
      if (b == 0) in_wlvl[2] = '0;
      else if (b >= 2 && b < 39) gen_random();
      if (b == 39) begin
        for (int i = 0; i < CH; i++) in_wlvl[i] = '0;
        ch_rd_en = '0;
      end else begin
        predict();
      end
      ack_down();
    end

    repeat (30) tick();
    chk("queue_drained", exp_q.size(), 0);
    chk("idle_no_req", {30'd0, sdram_wr_req, sdram_rd_req}, 0);
    chk("idle_busy", busy, 0);
    report();
  end

endmodule
